// File: rtl/fib_step_generator.sv
// Fibonacci term generator advanced by rising edges of step_clk.
// step_clk is sampled in the clk domain as a tick; it never clocks any flop.
// Optional build macro FIB_WRAP_EN: when defined, an overflowing term is
// emitted modulo 2^WIDTH and the run continues to MAX_TERMS terms; when
// undefined, the first overflowing advance ends the run.
module fib_step_generator #(
  parameter int WIDTH       = 32,
  parameter int MAX_TERMS   = 48,
  parameter int INDEX_WIDTH = 6
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   step_clk,
  input  logic                   start,
  input  logic                   fib_ready,
  output logic [WIDTH-1:0]       fib_value,
  output logic [INDEX_WIDTH-1:0] fib_index,
  output logic                   fib_valid,
  output logic                   busy,
  output logic                   done,
  output logic                   overflow,
  output logic                   lost_tick
);

`ifdef FIB_WRAP_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  localparam logic [INDEX_WIDTH-1:0] LAST_IDX = INDEX_WIDTH'(MAX_TERMS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                 state_q, state_d;
  logic                   step_q;
  logic                   pending_q, pending_d;
  logic [WIDTH-1:0]       a_q, a_d;
  logic [WIDTH-1:0]       b_q, b_d;
  logic                   b_ovf_q, b_ovf_d;
  logic [WIDTH-1:0]       value_q, value_d;
  logic [INDEX_WIDTH-1:0] index_q, index_d;
  logic                   valid_q, valid_d;
  logic                   ovf_q, ovf_d;
  logic                   lost_q, lost_d;

  logic                   tick;
  logic                   advance;
  logic [WIDTH:0]         sum;

  // Unsigned add keeping the carry so the caller can see whether the term fits.
  function automatic logic [WIDTH:0] fib_add(input logic [WIDTH-1:0] x,
                                             input logic [WIDTH-1:0] y);
    return {1'b0, x} + {1'b0, y};
  endfunction

  assign tick = step_clk & ~step_q;
  assign sum  = fib_add(a_q, b_q);

  // Next-state and datapath update; start overrides everything, including a tick.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    a_d       = a_q;
    b_d       = b_q;
    b_ovf_d   = b_ovf_q;
    value_d   = value_q;
    index_d   = index_q;
    valid_d   = valid_q;
    ovf_d     = ovf_q;
    lost_d    = lost_q;
    advance   = 1'b0;
    if (start) begin
      state_d   = RUN;
      pending_d = 1'b0;
      a_d       = '0;
      b_d       = WIDTH'(1);
      b_ovf_d   = 1'b0;
      value_d   = '0;
      index_d   = '0;
      valid_d   = 1'b1;
      ovf_d     = 1'b0;
      lost_d    = 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          advance = (pending_q | tick) & (~valid_q | fib_ready);
          if (valid_q && fib_ready) valid_d = 1'b0;
          if (advance) begin
            // A tick arriving while one is already queued becomes the new queued tick.
            pending_d = pending_q & tick;
            if (index_q == LAST_IDX) begin
              state_d = DONE;
            end else if (b_ovf_q && !WRAP_EN) begin
              ovf_d   = 1'b1;
              state_d = DONE;
            end else begin
              value_d = b_q;
              index_d = index_q + INDEX_WIDTH'(1);
              valid_d = 1'b1;
              a_d     = b_q;
              b_d     = sum[WIDTH-1:0];
              b_ovf_d = sum[WIDTH];
              if (b_ovf_q) ovf_d = 1'b1;
            end
          end else if (tick) begin
            pending_d = 1'b1;
            if (pending_q) lost_d = 1'b1;
          end
        end
        DONE: begin
          if (valid_q && fib_ready) valid_d = 1'b0;
        end
        default: ;
      endcase
    end
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      step_q    <= 1'b0;
      pending_q <= 1'b0;
      a_q       <= '0;
      b_q       <= WIDTH'(1);
      b_ovf_q   <= 1'b0;
      value_q   <= '0;
      index_q   <= '0;
      valid_q   <= 1'b0;
      ovf_q     <= 1'b0;
      lost_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      step_q    <= step_clk;
      pending_q <= pending_d;
      a_q       <= a_d;
      b_q       <= b_d;
      b_ovf_q   <= b_ovf_d;
      value_q   <= value_d;
      index_q   <= index_d;
      valid_q   <= valid_d;
      ovf_q     <= ovf_d;
      lost_q    <= lost_d;
    end
  end

  assign fib_value = value_q;
  assign fib_index = index_q;
  assign fib_valid = valid_q;
  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign overflow  = ovf_q;
  assign lost_tick = lost_q;

endmodule
